// File: rtl/aes_core_seq.sv
// Sequencer that wraps an iterative aes_core: optional key expansion, one block operation, then a result handshake.
// Optional macro AES_SEQ_OUT_SKID_EN adds a one-entry result buffer so a new request can start while a result waits.
module aes_core_seq (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_encdec,
    input  logic         in_keylen,
    input  logic         in_new_key,
    input  logic [255:0] in_key,
    input  logic [127:0] in_block,
    output logic         core_encdec,
    output logic         core_init,
    output logic         core_next,
    output logic         core_keylen,
    output logic [255:0] core_key,
    output logic [127:0] core_block,
    input  logic         core_ready,
    input  logic         core_result_valid,
    input  logic [127:0] core_result,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);
    typedef enum logic [2:0] {IDLE, KINIT, KWAIT, BNEXT, BWAIT, OUT} state_t;

    state_t        state;
    state_t        state_nx;
    logic          wait_first;
    logic          out_full;
    logic          accept;
    logic          room;
    logic          key_done;
    logic          block_done;
    logic          encdec_q;
    logic          keylen_q;
    logic [255:0]  key_q;
    logic [127:0]  block_q;
    logic [127:0]  result_q;

    assign in_ready = (state == IDLE);
    assign accept   = in_valid && in_ready;

`ifdef AES_SEQ_OUT_SKID_EN
    // A finished block may only land when the buffer is empty or draining this cycle.
    assign room = !out_full || out_ready;
`else
    assign room = 1'b1;
`endif

    // The core still shows the previous ready in the first wait cycle, so that cycle is ignored.
    assign key_done   = (state == KWAIT) && !wait_first && core_ready;
    assign block_done = (state == BWAIT) && !wait_first && core_ready && core_result_valid && room;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = in_new_key ? KINIT : BNEXT;
            KINIT:   state_nx = KWAIT;
            KWAIT:   if (key_done) state_nx = BNEXT;
            BNEXT:   state_nx = BWAIT;
            BWAIT:   if (block_done) state_nx = OUT;
`ifdef AES_SEQ_OUT_SKID_EN
            OUT:     state_nx = IDLE;
`else
            OUT:     if (out_ready) state_nx = IDLE;
`endif
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_first <= 1'b0;
            out_full   <= 1'b0;
            encdec_q   <= 1'b0;
            keylen_q   <= 1'b0;
            key_q      <= '0;
            block_q    <= '0;
            result_q   <= '0;
        end else begin
            wait_first <= (state == KINIT) || (state == BNEXT);
            if (accept) begin
                encdec_q <= in_encdec;
                keylen_q <= in_keylen;
                key_q    <= in_key;
                block_q  <= in_block;
            end
            if (block_done) begin
                result_q <= core_result;
                out_full <= 1'b1;
            end else if (out_full && out_ready) begin
                out_full <= 1'b0;
            end
        end
    end

    assign core_init   = (state == KINIT);
    assign core_next   = (state == BNEXT);
    assign core_encdec = encdec_q;
    assign core_keylen = keylen_q;
    assign core_key    = key_q;
    assign core_block  = block_q;
    assign out_valid   = out_full;
    assign out_data    = result_q;
endmodule
